// File: rtl/stream_frame_buffer_pp_pkg.sv
// Shared definitions for the ping-pong frame buffer: register map, bit positions and FSM encoding.
package stream_frame_buffer_pp_pkg;

    localparam logic [1:0] REGION_REGS  = 2'b00;
    localparam logic [1:0] REGION_BANK0 = 2'b10;
    localparam logic [1:0] REGION_BANK1 = 2'b11;

    // Register word indices (byte offset / 4)
    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_STATUS = 12'h001;
    localparam logic [11:0] REG_LEN0   = 12'h002;
    localparam logic [11:0] REG_LEN1   = 12'h003;
    localparam logic [11:0] REG_OVF    = 12'h004;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_REL0 = 1;
    localparam int CTRL_REL1 = 2;

    typedef enum logic [1:0] {
        FSM_IDLE    = 2'd0,
        FSM_CAPTURE = 2'd1,
        FSM_DROP    = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/stream_frame_buffer_pp_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port for the stream and one synchronous read port for the host.
module sfb_bank_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_frame_buffer_pp.sv
// Ping-pong frame capture: AXI-Stream frames land in one bank while the host reads the other over AHB-Lite.
module stream_frame_buffer_pp
    import stream_frame_buffer_pp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int OVF_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [DATA_W-1:0] tdata_s,
    input  logic              tlast_s,
    input  logic              tuser_s,
    input  logic              tvalid_s,
    output logic              tready_s,
    input  logic [31:0]       haddr_s,
    input  logic [1:0]        htrans_s,
    input  logic              hwrite_s,
    input  logic [2:0]        hsize_s,
    input  logic [2:0]        hburst_s,
    input  logic [31:0]       hwdata_s,
    input  logic              hsel_s,
    output logic [31:0]       hrdata_s,
    output logic              hreadyout_s,
    output logic              hresp_s,
    output logic              frame_irq
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    fsm_state_t        state;
    logic              wbank, drop_complete, ctrl_en;
    logic [1:0]        full, trunc, rel;
    logic [CNT_W-1:0]  cnt, len0, len1, done_len;
    logic [OVF_W-1:0]  ovf;
    logic              dp_valid, dp_write;
    logic [1:0]        dp_region;
    logic [11:0]       dp_idx;
    logic              beat, pick_ok, pick_bank, reg_wr, ctrl_wr, ovf_clr, ovf_inc;
    logic              wr_en, wr_bank, done, done_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] rd0, rd1;
    logic [31:0]       reg_rdata;
    logic              unused_ok;

    assign unused_ok   = ^{haddr_s[31:16], haddr_s[1:0], htrans_s[0], hsize_s, hburst_s, hwdata_s[31:3]};
    assign hreadyout_s = 1'b1;
    assign hresp_s     = 1'b0;
    assign tready_s    = ce & ctrl_en;
    assign beat        = ce & tvalid_s & tready_s;
    assign pick_ok     = ~full[wbank] | ~full[~wbank];
    assign pick_bank   = full[wbank] ? ~wbank : wbank;

    assign reg_wr  = dp_valid & dp_write & (dp_region == REGION_REGS);
    assign ctrl_wr = reg_wr & (dp_idx == REG_CTRL);
    assign ovf_clr = reg_wr & (dp_idx == REG_OVF);
    assign rel     = {ctrl_wr & hwdata_s[CTRL_REL1], ctrl_wr & hwdata_s[CTRL_REL0]};

    // AHB address phase is captured here; the matching data phase follows one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_region <= 2'b00;
            dp_idx    <= '0;
            ctrl_en   <= 1'b0;
        end else begin
            dp_valid  <= hsel_s & htrans_s[1];
            dp_write  <= hwrite_s;
            dp_region <= haddr_s[15:14];
            dp_idx    <= haddr_s[13:2];
            if (ctrl_wr) ctrl_en <= hwdata_s[CTRL_EN];
        end
    end

    // RAM write strobe, frame completion and overflow detection for the current beat
    always_comb begin
        wr_en     = 1'b0;
        wr_bank   = wbank;
        wr_addr   = cnt[ADDR_W-1:0];
        done      = 1'b0;
        done_bank = wbank;
        done_len  = cnt;
        ovf_inc   = 1'b0;
        case (state)
            FSM_IDLE: if (beat && tuser_s) begin
                if (pick_ok) begin
                    wr_en     = 1'b1;
                    wr_bank   = pick_bank;
                    wr_addr   = '0;
                    done      = tlast_s;
                    done_bank = pick_bank;
                    done_len  = CNT_W'(1);
                end else begin
                    ovf_inc = 1'b1;
                end
            end
            FSM_CAPTURE: if (beat) begin
                if (tuser_s) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    done     = tlast_s;
                    done_len = CNT_W'(1);
                end else if (cnt != CNT_MAX) begin
                    wr_en    = 1'b1;
                    done     = tlast_s;
                    done_len = cnt + 1'b1;
                end else begin
                    done = tlast_s;
                end
            end
            FSM_DROP: if (beat && tlast_s) done = drop_complete;
            default: ;
        endcase
    end

    // Completion overrides the state/bank decisions made in the case statement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FSM_IDLE;
            wbank         <= 1'b0;
            cnt           <= '0;
            full          <= 2'b00;
            trunc         <= 2'b00;
            len0          <= '0;
            len1          <= '0;
            drop_complete <= 1'b0;
            frame_irq     <= 1'b0;
        end else begin
            frame_irq <= done;
            full      <= full & ~rel;
            case (state)
                FSM_IDLE: if (beat && tuser_s) begin
                    if (pick_ok) begin
                        wbank            <= pick_bank;
                        trunc[pick_bank] <= 1'b0;
                        cnt              <= CNT_W'(1);
                        state            <= FSM_CAPTURE;
                    end else begin
                        drop_complete <= 1'b0;
                        state         <= tlast_s ? FSM_IDLE : FSM_DROP;
                    end
                end
                FSM_CAPTURE: if (beat) begin
                    if (tuser_s) begin
                        cnt <= CNT_W'(1);
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        trunc[wbank]  <= 1'b1;
                        drop_complete <= 1'b1;
                        state         <= FSM_DROP;
                    end
                end
                FSM_DROP: if (beat && tlast_s) state <= FSM_IDLE;
                default: state <= FSM_IDLE;
            endcase
            if (done) begin
                full[done_bank] <= 1'b1;
                if (done_bank) len1 <= done_len;
                else           len0 <= done_len;
                wbank <= ~done_bank;
                state <= FSM_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    ovf <= '0;
        else if (ovf_clr)                ovf <= '0;
        else if (ovf_inc && ovf != '1)   ovf <= ovf + 1'b1;
    end

    always_comb begin
        reg_rdata = 32'h0;
        case (dp_idx)
            REG_CTRL:   reg_rdata = {31'h0, ctrl_en};
            REG_STATUS: reg_rdata = {26'h0, trunc, (state == FSM_CAPTURE), wbank, full};
            REG_LEN0:   reg_rdata = 32'(len0);
            REG_LEN1:   reg_rdata = 32'(len1);
            REG_OVF:    reg_rdata = 32'(ovf);
            default:    reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        hrdata_s = 32'h0;
        if (dp_valid && !dp_write) begin
            case (dp_region)
                REGION_REGS:  hrdata_s = reg_rdata;
                REGION_BANK0: hrdata_s = 32'(rd0);
                REGION_BANK1: hrdata_s = 32'(rd1);
                default:      hrdata_s = 32'h0;
            endcase
        end
    end

    sfb_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk   (clk),
        .we    (wr_en & ~wr_bank),
        .waddr (wr_addr),
        .wdata (tdata_s),
        .raddr (haddr_s[ADDR_W+1:2]),
        .rdata (rd0)
    );

    sfb_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk   (clk),
        .we    (wr_en & wr_bank),
        .waddr (wr_addr),
        .wdata (tdata_s),
        .raddr (haddr_s[ADDR_W+1:2]),
        .rdata (rd1)
    );

endmodule

// File: tb/tb_stream_frame_buffer_pp.sv
// Scoreboard bench for stream_frame_buffer_pp: host reads queue their expected data, a monitor checks each data phase.
module tb_stream_frame_buffer_pp;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int OVF_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ce = 1'b1;
    logic [DATA_W-1:0] tdata_s = '0;
    logic              tlast_s = 1'b0, tuser_s = 1'b0, tvalid_s = 1'b0;
    logic              tready_s;
    logic [31:0]       haddr_s = '0, hwdata_s = '0;
    logic [1:0]        htrans_s = 2'b00;
    logic              hwrite_s = 1'b0, hsel_s = 1'b0;
    logic [2:0]        hsize_s = 3'b010, hburst_s = 3'b000;
    logic [31:0]       hrdata_s;
    logic              hreadyout_s, hresp_s, frame_irq;

    int checks = 0;
    int errors = 0;
    int irq_count = 0;
    int tready_low = 0;
    string       exp_name[$];
    logic [31:0] exp_data[$];
    logic        rd_pending;

    stream_frame_buffer_pp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .tdata_s(tdata_s), .tlast_s(tlast_s), .tuser_s(tuser_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
        .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s), .hsize_s(hsize_s), .hburst_s(hburst_s),
        .hwdata_s(hwdata_s), .hsel_s(hsel_s), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
        .hresp_s(hresp_s), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read data phase pops one expected entry
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pending <= 1'b0;
        else          rd_pending <= hsel_s & htrans_s[1] & ~hwrite_s;
    end

    always @(negedge clk) begin
        if (frame_irq) irq_count++;
        if (ce && tvalid_s && !tready_s) tready_low++;
        if (reset_n && rd_pending) begin
            check_output("hreadyout", {31'h0, hreadyout_s}, 32'h1);
            if (exp_data.size() == 0) begin
                check_output("unexpected_read", hrdata_s, 32'hDEAD_BEEF);
            end else begin
                check_output(exp_name.pop_front(), hrdata_s, exp_data.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = addr;
        cycle();
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = data;
        cycle();
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_name.push_back(name);
        exp_data.push_back(exp);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = addr;
        cycle();
        hsel_s = 1'b0; htrans_s = 2'b00;
        cycle();
    endtask

    // Sends beats first..first+num-1 of a frame of length total
    task automatic apply_stimulus(input int first, input int num, input int total, input int base,
                                  input bit toggle_ce);
        bit accepted;
        int guard;
        for (int i = first; i < first + num; i++) begin
            tvalid_s = 1'b1;
            tdata_s  = DATA_W'(base + i);
            tuser_s  = (i == 0);
            tlast_s  = (i == total - 1);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted) begin
                ce = toggle_ce ? ~ce : 1'b1;
                @(negedge clk);
                accepted = ce && tready_s;
                @(posedge clk);
                #1;
                guard++;
                if (!accepted && guard > 50) begin
                    check_output("stream_timeout", 32'(guard), 32'h0);
                    accepted = 1'b1;
                end
            end
        end
        tvalid_s = 1'b0; tuser_s = 1'b0; tlast_s = 1'b0; ce = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_tready"}, {31'h0, tready_s}, 32'h0);
        check_output({tag, "_hrdata"}, hrdata_s, 32'h0);
        check_output({tag, "_hready"}, {31'h0, hreadyout_s}, 32'h1);
        check_output({tag, "_hresp"}, {31'h0, hresp_s}, 32'h0);
        check_output({tag, "_irq"}, {31'h0, frame_irq}, 32'h0);
    endtask

    initial begin
        cycle(); cycle();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        cycle();
        ahb_read(32'h4, 32'h0, "rst_status");
        ahb_read(32'h8, 32'h0, "rst_len0");
        ahb_read(32'h10, 32'h0, "rst_ovf");

        $display("[TB] single frame into bank0");
        ahb_write(32'h0, 32'h1);
        ahb_read(32'h0, 32'h1, "ctrl_en");
        apply_stimulus(0, 8, 8, 0, 1'b0);
        cycle(); cycle();
        check_output("irq_frame1", 32'(irq_count), 32'd1);
        ahb_read(32'h4, 32'h5, "status_frame1");
        ahb_read(32'h8, 32'h8, "len0_frame1");
        for (int i = 0; i < 8; i++) ahb_read(32'h8000 + 32'(4 * i), 32'(i), "bank0_word");

        $display("[TB] both banks full then overflow");
        apply_stimulus(0, 8, 8, 100, 1'b0);
        cycle(); cycle();
        ahb_read(32'h4, 32'h3, "status_two_full");
        ahb_read(32'hC01C, 32'd107, "bank1_word7");
        apply_stimulus(0, 4, 4, 150, 1'b0);
        cycle(); cycle();
        check_output("tready_during_drop", 32'(tready_low), 32'd0);
        check_output("irq_after_drop", 32'(irq_count), 32'd2);
        ahb_read(32'h10, 32'h1, "ovf_one");
        ahb_read(32'h4, 32'h3, "status_after_drop");
        ahb_write(32'h10, 32'h1234);
        ahb_read(32'h10, 32'h0, "ovf_cleared");
        ahb_write(32'h0, 32'h7);
        ahb_read(32'h4, 32'h0, "status_released");

        $display("[TB] oversized frame truncates");
        apply_stimulus(0, 20, DEPTH + 5, 200, 1'b0);
        cycle(); cycle();
        check_output("irq_before_tlast", 32'(irq_count), 32'd2);
        ahb_read(32'h4, 32'h10, "status_truncating");
        apply_stimulus(20, 1, DEPTH + 5, 200, 1'b0);
        cycle(); cycle();
        check_output("irq_trunc_done", 32'(irq_count), 32'd3);
        ahb_read(32'h4, 32'h15, "status_trunc");
        ahb_read(32'h8, 32'(DEPTH), "len0_trunc");
        ahb_read(32'h8000, 32'd200, "bank0_trunc_w0");
        ahb_read(32'h803C, 32'd215, "bank0_trunc_w15");
        apply_stimulus(0, 3, 3, 300, 1'b0);
        cycle(); cycle();
        ahb_read(32'h4, 32'h13, "status_after_trunc");
        ahb_read(32'hC, 32'h3, "len1_short");
        ahb_read(32'hC008, 32'd302, "bank1_w2");

        $display("[TB] release coincides with completion");
        ahb_write(32'h0, 32'h5);
        apply_stimulus(0, 3, 4, 400, 1'b0);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = 32'h0;
        cycle();
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = 32'h3;
        tvalid_s = 1'b1; tdata_s = DATA_W'(403); tlast_s = 1'b1; tuser_s = 1'b0;
        cycle();
        tvalid_s = 1'b0; tlast_s = 1'b0;
        cycle();
        check_output("irq_coincide", 32'(irq_count), 32'd5);
        ahb_read(32'h4, 32'h12, "status_coincide");
        ahb_read(32'hC, 32'h4, "len1_coincide");
        apply_stimulus(0, 2, 2, 500, 1'b0);
        cycle(); cycle();
        ahb_read(32'h4, 32'h7, "status_sof_bank0");
        ahb_read(32'h8, 32'h2, "len0_sof_bank0");
        ahb_read(32'h8004, 32'd501, "bank0_w1_sof");
        apply_stimulus(0, 2, 2, 550, 1'b0);
        cycle();
        ahb_read(32'h10, 32'h1, "ovf_before_reset");

        $display("[TB] reset mid-frame");
        ahb_write(32'h0, 32'h7);
        apply_stimulus(0, 3, 10, 600, 1'b0);
        reset_n = 1'b0;
        cycle();
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        cycle();
        ahb_read(32'h4, 32'h0, "status_after_reset");
        ahb_read(32'h10, 32'h0, "ovf_after_reset");
        ahb_read(32'hC, 32'h0, "len1_after_reset");
        ahb_read(32'h0, 32'h0, "ctrl_after_reset");
        ahb_write(32'h0, 32'h1);
        apply_stimulus(0, 3, 3, 700, 1'b0);
        cycle(); cycle();
        ahb_read(32'h8, 32'h3, "len0_after_reset");
        ahb_read(32'h8000, 32'd700, "bank0_w0_after_reset");
        ahb_read(32'h8008, 32'd702, "bank0_w2_after_reset");
        ahb_read(32'h4, 32'h5, "status_post_reset_frame");

        $display("[TB] ce toggling frame");
        fork
            apply_stimulus(0, 16, 16, 800, 1'b1);
            begin
                cycle(); cycle();
                ahb_read(32'h8, 32'h3, "len0_during_ce_toggle");
            end
        join
        cycle(); cycle();
        check_output("irq_total", 32'(irq_count), 32'd8);
        ahb_read(32'hC, 32'h10, "len1_ce_toggle");
        ahb_read(32'hC000, 32'd800, "bank1_ce_w0");
        ahb_read(32'hC01C, 32'd807, "bank1_ce_w7");
        ahb_read(32'hC03C, 32'd815, "bank1_ce_w15");
        ahb_read(32'h4, 32'h3, "status_ce_toggle");
        ahb_read(32'h20, 32'h0, "unmapped_reg");

        cycle();
        check_output("scoreboard_drained", 32'(exp_data.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
